// File: rtl/scs8hd_pipe_pkg.sv
// Shared helpers for the scs8hd elastic register pipeline:
// occupancy-counter sizing and a population count over the valid bits.
package scs8hd_pipe_pkg;

  // Widest valid vector the popcount helper handles (DEPTH must not exceed this).
  localparam int POP_MAX = 64;

  // Bits needed to hold a count from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Number of set bits in a zero-extended valid vector.
  function automatic int popcount(input logic [POP_MAX-1:0] bits);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n = n + {31'd0, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/scs8hd_dfrtp_pipe_stage.sv
// One pipeline stage: WIDTH data flops plus a valid flop.
// Scan shifts data LSB-first toward the MSB and leaves valid untouched;
// in normal mode the stage either loads its predecessor or holds.
module scs8hd_dfrtp_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             sce,
  input  logic             load,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             prev_valid,
  input  logic             scan_in,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             scan_out
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic             valid_reg;
  logic             valid_next;
  logic [WIDTH-1:0] scan_shifted;

  // Scan moves every bit one place up; scan_in enters at bit 0.
  generate
    if (WIDTH == 1) begin : g_scan_1bit
      assign scan_shifted = scan_in;
    end else begin : g_scan_nbit
      assign scan_shifted = {data_reg[WIDTH-2:0], scan_in};
    end
  endgenerate

  // Next state: scan shift beats a normal load; a bubble still copies data.
  always_comb begin
    data_next  = data_reg;
    valid_next = valid_reg;
    if (sce) begin
      data_next = scan_shifted;
    end else if (load) begin
      data_next  = prev_data;
      valid_next = prev_valid;
    end
  end

  // State register with synchronous reset to RESET_VAL / empty.
  always_ff @(posedge CLK) begin
    if (reset) begin
      data_reg  <= RESET_VAL;
      valid_reg <= 1'b0;
    end else begin
      data_reg  <= data_next;
      valid_reg <= valid_next;
    end
  end

  assign data     = data_reg;
  assign valid    = valid_reg;
  assign scan_out = data_reg[WIDTH-1];

endmodule

// File: rtl/scs8hd_dfrtp_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready flow control,
// bubble collapsing and a single serial scan chain through every data bit.
module scs8hd_dfrtp_pipe
  import scs8hd_pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [WIDTH-1:0]              D,
  input  logic                          D_VALID,
  output logic                          D_READY,
  output logic [WIDTH-1:0]              Q,
  output logic                          Q_VALID,
  input  logic                          Q_READY,
  input  logic                          SCE,
  input  logic                          SCD,
  output logic                          SCQ,
  output logic [count_width(DEPTH)-1:0] COUNT
);

  localparam int CW = count_width(DEPTH);

  // acc[i]: stage i may take a new value this edge (empty, or everything
  // downstream of it moves). acc[DEPTH] is the consumer's ready.
  logic [DEPTH:0]     acc;
  logic [DEPTH-1:0]   stage_valid;
  logic [DEPTH-1:0]   stage_scan;
  logic [WIDTH-1:0]   stage_data [DEPTH];
  logic [DEPTH-1:0]   in_valid;
  logic [DEPTH-1:0]   in_scan;
  logic [WIDTH-1:0]   in_data [DEPTH];
  logic               push;
  logic [POP_MAX-1:0] valid_ext;

  assign acc[DEPTH] = Q_READY;
  assign D_READY    = acc[0] && !SCE && !RESET;
  assign push       = D_VALID && D_READY;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign acc[gi] = !stage_valid[gi] || acc[gi+1];

      // Stage 0 is fed by the upstream port and SCD; later stages by their predecessor.
      if (gi == 0) begin : g_head
        assign in_data[gi]  = D;
        assign in_valid[gi] = push;
        assign in_scan[gi]  = SCD;
      end else begin : g_body
        assign in_data[gi]  = stage_data[gi-1];
        assign in_valid[gi] = stage_valid[gi-1];
        assign in_scan[gi]  = stage_scan[gi-1];
      end

      scs8hd_dfrtp_pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .CLK        (CLK),
        .reset      (RESET),
        .sce        (SCE),
        .load       (acc[gi]),
        .prev_data  (in_data[gi]),
        .prev_valid (in_valid[gi]),
        .scan_in    (in_scan[gi]),
        .data       (stage_data[gi]),
        .valid      (stage_valid[gi]),
        .scan_out   (stage_scan[gi])
      );
    end
  endgenerate

  // Output valid is suppressed during scan so nothing is consumed mid-shift.
  assign Q       = stage_data[DEPTH-1];
  assign Q_VALID = stage_valid[DEPTH-1] && !SCE;
  assign SCQ     = stage_scan[DEPTH-1];

  assign valid_ext = POP_MAX'(stage_valid);
  assign COUNT     = CW'(popcount(valid_ext));

endmodule
